// File: rtl/riscv_io_responder.sv
// riscv_io_responder: memory-mapped I/O slave for a small RISC-V core.
// Four registers are decoded from m_addr[3:2]: DATA, STATUS, CTRL and CYCLE.
// DATA reads pop the inbound (RX) FIFO and DATA writes push the outbound (TX)
// FIFO. Both FIFOs connect to external valid/ready streams. A level interrupt
// is raised from the FIFO state, masked by CTRL.
module riscv_io_responder #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] m_addr,
   input  logic [31:0] d_t_mem,
   input  logic        io_wrn,
   input  logic        io_rdn,
   output logic [31:0] d_f_io,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_CYCLE  = 2'd3
   } reg_sel_e;

   // FIFO storage (deliberately not reset) and architectural state
   logic [7:0]    rx_mem_q [DEPTH];
   logic [7:0]    tx_mem_q [DEPTH];
   logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          tx_ovf_q, tx_ovf_d;
   logic [31:0]   cycle_q, cycle_d;

   // Decode and handshake qualifiers
   reg_sel_e      sel_s;
   logic          rd_s, wr_s;
   logic          rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
   logic          rx_push_s, rx_pop_s, tx_wr_s, tx_push_s, tx_pop_s;
   logic [4:0]    rx_cnt5_s, tx_cnt5_s;
   logic [31:0]   status_s;
   logic [31:0]   rd_data_s;
   logic          unused_s;

   assign sel_s      = reg_sel_e'(m_addr[3:2]);
   assign rd_s       = ~io_rdn;
   assign wr_s       = ~io_wrn;
   assign unused_s   = ^{m_addr[31:4], m_addr[1:0]};

   assign rx_empty_s = (rx_cnt_q == CNT_ZERO);
   assign rx_full_s  = (rx_cnt_q == FULL_CNT);
   assign tx_empty_s = (tx_cnt_q == CNT_ZERO);
   assign tx_full_s  = (tx_cnt_q == FULL_CNT);

   // A pop in the same cycle never frees room for a push: fullness is pre-edge.
   assign rx_push_s  = rx_valid & ~rx_full_s;
   assign rx_pop_s   = rd_s & (sel_s == REG_DATA) & ~rx_empty_s;
   assign tx_wr_s    = wr_s & (sel_s == REG_DATA);
   assign tx_push_s  = tx_wr_s & ~tx_full_s;
   assign tx_pop_s   = ~tx_empty_s & tx_ready;

   assign rx_cnt5_s  = 5'(rx_cnt_q);
   assign tx_cnt5_s  = 5'(tx_cnt_q);
   assign status_s   = {11'h0, tx_cnt5_s, 3'h0, rx_cnt5_s, 3'h0,
                        tx_ovf_q, tx_full_s, tx_empty_s, rx_full_s, ~rx_empty_s};

   assign rx_ready   = ~rx_full_s;
   assign tx_valid   = ~tx_empty_s;
   assign tx_data    = tx_empty_s ? 8'h00 : tx_mem_q[tx_rp_q];
   assign irq        = (ctrl_q[0] & ~rx_empty_s) | (ctrl_q[1] & tx_empty_s);
   assign d_f_io     = rd_data_s;

   // Next-state for FIFO pointers/counts and the CPU-visible registers
   always_comb begin
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      ctrl_d   = ctrl_q;
      tx_ovf_d = tx_ovf_q;
      cycle_d  = cycle_q;

      if (rx_push_s) begin
         rx_wp_d = rx_wp_q + PTR_ONE;
      end else begin
         rx_wp_d = rx_wp_q;
      end
      if (rx_pop_s) begin
         rx_rp_d = rx_rp_q + PTR_ONE;
      end else begin
         rx_rp_d = rx_rp_q;
      end
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
         2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
         default: rx_cnt_d = rx_cnt_q;
      endcase

      if (tx_push_s) begin
         tx_wp_d = tx_wp_q + PTR_ONE;
      end else begin
         tx_wp_d = tx_wp_q;
      end
      if (tx_pop_s) begin
         tx_rp_d = tx_rp_q + PTR_ONE;
      end else begin
         tx_rp_d = tx_rp_q;
      end
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
         2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
         default: tx_cnt_d = tx_cnt_q;
      endcase

      // A dropped TX byte sets the sticky overflow; only a STATUS write clears it
      if (tx_wr_s && tx_full_s) begin
         tx_ovf_d = 1'b1;
      end else if (wr_s && (sel_s == REG_STATUS) && d_t_mem[4]) begin
         tx_ovf_d = 1'b0;
      end else begin
         tx_ovf_d = tx_ovf_q;
      end

      if (wr_s && (sel_s == REG_CTRL)) begin
         ctrl_d = d_t_mem[1:0];
      end else begin
         ctrl_d = ctrl_q;
      end

      if (wr_s && (sel_s == REG_CYCLE)) begin
         cycle_d = d_t_mem;
      end else begin
         cycle_d = cycle_q + 32'd1;
      end
   end

   // State register; clr wins over every strobe and handshake
   always_ff @(posedge clk) begin
      if (clr) begin
         rx_wp_q  <= {PW{1'b0}};
         rx_rp_q  <= {PW{1'b0}};
         rx_cnt_q <= CNT_ZERO;
         tx_wp_q  <= {PW{1'b0}};
         tx_rp_q  <= {PW{1'b0}};
         tx_cnt_q <= CNT_ZERO;
         ctrl_q   <= 2'b00;
         tx_ovf_q <= 1'b0;
         cycle_q  <= 32'h0;
      end else begin
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         ctrl_q   <= ctrl_d;
         tx_ovf_q <= tx_ovf_d;
         cycle_q  <= cycle_d;
      end
   end

   // FIFO storage writes; no reset so the arrays map onto plain RAM
   always_ff @(posedge clk) begin
      if (!clr && rx_push_s) begin
         rx_mem_q[rx_wp_q] <= rx_data;
      end
      if (!clr && tx_push_s) begin
         tx_mem_q[tx_wp_q] <= d_t_mem[7:0];
      end
   end

   // CPU read mux, combinational from pre-edge state; zero when not reading
   always_comb begin
      rd_data_s = 32'h0;
      if (rd_s) begin
         case (sel_s)
            REG_DATA:   rd_data_s = rx_empty_s ? 32'h0 : {24'h0, rx_mem_q[rx_rp_q]};
            REG_STATUS: rd_data_s = status_s;
            REG_CTRL:   rd_data_s = {30'h0, ctrl_q};
            REG_CYCLE:  rd_data_s = cycle_q;
            default:    rd_data_s = 32'h0;
         endcase
      end else begin
         rd_data_s = 32'h0;
      end
   end

endmodule

// File: tb/tb_riscv_io_responder.sv
// tb_riscv_io_responder: directed, table-driven bench for riscv_io_responder
// (DEPTH = 8). Inputs change on the falling edge and outputs are compared
// 1 time unit later, so every expectation reflects the pre-edge state.
module tb_riscv_io_responder;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] m_addr;
   logic [31:0] d_t_mem;
   logic        io_wrn;
   logic        io_rdn;
   logic [31:0] d_f_io;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   int n_checks = 0;
   int n_err    = 0;

   riscv_io_responder #(.DEPTH(8)) dut (
      .clk(clk), .clr(clr), .m_addr(m_addr), .d_t_mem(d_t_mem),
      .io_wrn(io_wrn), .io_rdn(io_rdn), .d_f_io(d_f_io),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic        rdn;
      logic        wrn;
      logic [31:0] wdata;
      logic        rxv;
      logic [7:0]  rxd;
      logic        txr;
      logic [31:0] e_dout;
      logic        e_rxr;
      logic        e_txv;
      logic [7:0]  e_txd;
      logic        e_irq;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [1:0] sel, input logic rdn, input logic wrn,
                               input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                               input logic txr, input logic [31:0] e_dout, input logic e_rxr,
                               input logic e_txv, input logic [7:0] e_txd, input logic e_irq);
      vec_t v;
      v.sel = sel; v.rdn = rdn; v.wrn = wrn; v.wdata = wdata;
      v.rxv = rxv; v.rxd = rxd; v.txr = txr;
      v.e_dout = e_dout; v.e_rxr = e_rxr; v.e_txv = e_txv;
      v.e_txd = e_txd; v.e_irq = e_irq;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      m_addr   = {28'h0, v.sel, 2'b00};
      io_rdn   = v.rdn;
      io_wrn   = v.wrn;
      d_t_mem  = v.wdata;
      rx_valid = v.rxv;
      rx_data  = v.rxd;
      tx_ready = v.txr;
      #1;
      chk($sformatf("v%0d d_f_io", idx),   d_f_io,               v.e_dout);
      chk($sformatf("v%0d rx_ready", idx), {31'h0, rx_ready},    {31'h0, v.e_rxr});
      chk($sformatf("v%0d tx_valid", idx), {31'h0, tx_valid},    {31'h0, v.e_txv});
      chk($sformatf("v%0d tx_data", idx),  {24'h0, tx_data},     {24'h0, v.e_txd});
      chk($sformatf("v%0d irq", idx),      {31'h0, irq},         {31'h0, v.e_irq});
   endtask

   task automatic set_addr(input logic [1:0] sel);
      m_addr = {28'h0, sel, 2'b00};
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // RX: push 0x41, 0x42 then read them back, then read empty
      add(2'd0,1,1,32'h0,0,8'h00,0, 32'h0,1,0,8'h00,0);
      add(2'd0,1,1,32'h0,1,8'h41,0, 32'h0,1,0,8'h00,0);
      add(2'd0,1,1,32'h0,1,8'h42,0, 32'h0,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0205,1,0,8'h00,0);
      add(2'd0,0,1,32'h0,0,8'h00,0, 32'h0000_0041,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0105,1,0,8'h00,0);
      add(2'd0,0,1,32'h0,0,8'h00,0, 32'h0000_0042,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0004,1,0,8'h00,0);
      add(2'd0,0,1,32'h0,0,8'h00,0, 32'h0,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0004,1,0,8'h00,0);
      // TX: nine writes into a depth-8 FIFO with tx_ready low
      for (int k = 0; k < 9; k++) begin
         add(2'd0,1,0,32'h10 + 32'(k),0,8'h00,0, 32'h0,1,(k > 0),(k > 0) ? 8'h10 : 8'h00,0);
      end
      add(2'd1,0,1,32'h0,0,8'h00,0,  32'h0008_0018,1,1,8'h10,0);
      add(2'd1,0,0,32'h10,0,8'h00,0, 32'h0008_0018,1,1,8'h10,0);
      add(2'd1,0,1,32'h0,0,8'h00,0,  32'h0008_0008,1,1,8'h10,0);
      // Drain TX; the dropped 0x18 must never appear
      for (int k = 0; k < 8; k++) begin
         add(2'd0,1,1,32'h0,0,8'h00,1, 32'h0,1,1,8'h10 + 8'(k),0);
      end
      add(2'd0,1,1,32'h0,0,8'h00,1, 32'h0,1,0,8'h00,0);
      // TX simultaneous push and pop
      add(2'd0,1,0,32'h55,0,8'h00,1, 32'h0,1,0,8'h00,0);
      add(2'd0,1,0,32'h66,0,8'h00,1, 32'h0,1,1,8'h55,0);
      add(2'd0,1,1,32'h0,0,8'h00,1,  32'h0,1,1,8'h66,0);
      add(2'd0,1,1,32'h0,0,8'h00,0,  32'h0,1,0,8'h00,0);
      // RX simultaneous push and pop
      add(2'd0,1,1,32'h0,1,8'h77,0, 32'h0,1,0,8'h00,0);
      add(2'd0,0,1,32'h0,1,8'h88,0, 32'h0000_0077,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0105,1,0,8'h00,0);
      add(2'd0,0,1,32'h0,0,8'h00,0, 32'h0000_0088,1,0,8'h00,0);
      add(2'd1,0,1,32'h0,0,8'h00,0, 32'h0000_0004,1,0,8'h00,0);
      // CTRL masking and rx_ie interrupt
      add(2'd2,1,0,32'hFFFF_FFFD,0,8'h00,0, 32'h0,1,0,8'h00,0);
      add(2'd2,0,1,32'h0,0,8'h00,0, 32'h0000_0001,1,0,8'h00,0);
      add(2'd0,1,1,32'h0,1,8'h99,0, 32'h0,1,0,8'h00,0);
      add(2'd0,1,1,32'h0,0,8'h00,0, 32'h0,1,0,8'h00,1);
      add(2'd0,0,1,32'h0,0,8'h00,0, 32'h0000_0099,1,0,8'h00,1);
      add(2'd0,1,1,32'h0,0,8'h00,0, 32'h0,1,0,8'h00,0);
      add(2'd2,1,0,32'h0,0,8'h00,0, 32'h0,1,0,8'h00,0);

      clr = 1'b1; m_addr = 32'h0; d_t_mem = 32'h0; io_wrn = 1'b1; io_rdn = 1'b1;
      rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         run_vec(vq[i], i);
      end

      // Fill RX with rx_valid held; a pop on a full FIFO does not admit a push
      @(negedge clk);
      io_rdn = 1'b1; io_wrn = 1'b1; tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
         #1;
         chk($sformatf("fill%0d rx_ready", i), {31'h0, rx_ready}, 32'h1);
         @(negedge clk);
      end
      rx_data = 8'hA8;
      #1;
      chk("full rx_ready", {31'h0, rx_ready}, 32'h0);
      set_addr(2'd1); io_rdn = 1'b0;
      #1;
      chk("full status", d_f_io, 32'h0000_0807);
      @(negedge clk);
      set_addr(2'd0);
      #1;
      chk("pop on full data", d_f_io, 32'h0000_00A0);
      chk("pop on full rx_ready", {31'h0, rx_ready}, 32'h0);
      @(negedge clk);
      io_rdn = 1'b1;
      #1;
      chk("after pop rx_ready", {31'h0, rx_ready}, 32'h1);
      @(negedge clk);
      rx_valid = 1'b0;
      set_addr(2'd1); io_rdn = 1'b0;
      #1;
      chk("ninth accepted status", d_f_io, 32'h0000_0807);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         set_addr(2'd0); io_rdn = 1'b0;
         #1;
         chk($sformatf("drain%0d data", i), d_f_io, 32'h0000_00A0 + 32'(i));
      end
      @(negedge clk);
      io_rdn = 1'b1;

      // CYCLE load and wrap
      set_addr(2'd3); io_wrn = 1'b0; d_t_mem = 32'hFFFF_FFFE;
      @(negedge clk);
      io_wrn = 1'b1; io_rdn = 1'b0;
      #1;
      chk("cycle loaded", d_f_io, 32'hFFFF_FFFE);
      @(negedge clk);
      #1;
      chk("cycle max", d_f_io, 32'hFFFF_FFFF);
      @(negedge clk);
      #1;
      chk("cycle wrap", d_f_io, 32'h0);
      @(negedge clk);
      io_rdn = 1'b1;

      // tx_ie interrupt follows TX emptiness
      set_addr(2'd2); io_wrn = 1'b0; d_t_mem = 32'h2;
      @(negedge clk);
      io_wrn = 1'b1;
      #1;
      chk("tx_ie irq empty", {31'h0, irq}, 32'h1);
      @(negedge clk);
      set_addr(2'd0); io_wrn = 1'b0; d_t_mem = 32'h33;
      #1;
      chk("tx_ie irq pre-write", {31'h0, irq}, 32'h1);
      @(negedge clk);
      io_wrn = 1'b1;
      #1;
      chk("tx_ie irq after write", {31'h0, irq}, 32'h0);
      chk("tx_ie tx_data", {24'h0, tx_data}, 32'h33);
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      chk("tx_ie irq pre-drain", {31'h0, irq}, 32'h0);
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      chk("tx_ie irq drained", {31'h0, irq}, 32'h1);
      chk("tx_ie tx_valid drained", {31'h0, tx_valid}, 32'h0);
      set_addr(2'd2); io_wrn = 1'b0; d_t_mem = 32'h0;
      @(negedge clk);
      io_wrn = 1'b1;

      // Reset mid-transfer with three TX entries and a pending write
      for (int i = 0; i < 3; i++) begin
         set_addr(2'd0); io_wrn = 1'b0; d_t_mem = 32'hC1 + 32'(i);
         @(negedge clk);
      end
      io_wrn = 1'b1; set_addr(2'd1); io_rdn = 1'b0;
      #1;
      chk("pre-reset status", d_f_io, 32'h0003_0000);
      chk("pre-reset tx_data", {24'h0, tx_data}, 32'hC1);
      @(negedge clk);
      clr = 1'b1; io_rdn = 1'b1;
      set_addr(2'd0); io_wrn = 1'b0; d_t_mem = 32'hC4;
      rx_valid = 1'b1; rx_data = 8'hEE; tx_ready = 1'b1;
      @(negedge clk);
      clr = 1'b0; io_wrn = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
      #1;
      chk("reset tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("reset tx_data", {24'h0, tx_data}, 32'h0);
      chk("reset rx_ready", {31'h0, rx_ready}, 32'h1);
      chk("reset irq", {31'h0, irq}, 32'h0);
      chk("reset d_f_io idle", d_f_io, 32'h0);
      set_addr(2'd1); io_rdn = 1'b0;
      #1;
      chk("reset status", d_f_io, 32'h0000_0004);
      set_addr(2'd3);
      #1;
      chk("reset cycle", d_f_io, 32'h0);
      @(negedge clk);
      io_rdn = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
